zdelay_ctrl: RTL

//   Sequencer for a RAM-backed programmable delay line z^-D, generalising the unit

---
 rtl/zdelay_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/zdelay_ctrl.sv
// Sequencer for a RAM-backed programmable delay line z^-D over one circular buffer.
// One sample per strobe: RD -> WAIT -> WR, out_valid 3 cycles after accept; strobes while busy are dropped and flag overrun.
module zdelay_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [BITWIDTH-1:0] sample_in,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic                delay_load,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [BITWIDTH-1:0] mem_rdata,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [BITWIDTH-1:0] mem_wdata,
  output logic [BITWIDTH-1:0] sample_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun,
  output logic [ADDR_W-1:0]   delay_active
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   fill;
  logic [ADDR_W-1:0]   pend_len;
  logic                pend_flag;
  logic [BITWIDTH-1:0] samp_q;
  logic [ADDR_W-1:0]   d_next;

  // A load coincident with the accepting strobe takes priority over an older pending one.
  always_comb begin
    d_next = delay_active;
    if (delay_load)
      d_next = delay_len;
    else if (pend_flag)
      d_next = pend_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wptr         <= '0;
      fill         <= '0;
      pend_len     <= '0;
      pend_flag    <= 1'b0;
      samp_q       <= '0;
      mem_re       <= 1'b0;
      mem_raddr    <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      sample_out   <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      delay_active <= '0;
    end else begin
      mem_re    <= 1'b0;
      mem_raddr <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;

      if (delay_load) begin
        pend_len  <= delay_len;
        pend_flag <= 1'b1;
      end

      if (state != IDLE && sample_valid)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_valid) begin
            samp_q       <= sample_in;
            delay_active <= d_next;
            pend_flag    <= 1'b0;
            mem_re       <= 1'b1;
            mem_raddr    <= wptr - d_next;
            busy         <= 1'b1;
            state        <= RD;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          // Read data from RD is on mem_rdata now; read-before-write makes D=1 the previous sample.
          if (delay_active == '0)
            sample_out <= samp_q;
          else if (fill < delay_active)
            sample_out <= '0;
          else
            sample_out <= mem_rdata;
          out_valid <= 1'b1;
          mem_we    <= 1'b1;
          mem_waddr <= wptr;
          mem_wdata <= samp_q;
          wptr      <= wptr + 1'b1;
          if (fill != FILL_MAX)
            fill <= fill + 1'b1;
          state <= WR;
        end
        WR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
